// File: rtl/decode_pkg.sv
// Shared constants, the IF/ID entry type and skid-buffer state encoding for the decode stage.
package decode_pkg;

  localparam int unsigned DEC_INSTR_W = 16;
  localparam int unsigned DEC_PC_W    = 16;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_LSB = 0;
  localparam int unsigned FIELD_W = 4;
  localparam int unsigned IMM_W   = 8;

  typedef struct packed {
    logic [DEC_INSTR_W-1:0] ir;
    logic [DEC_PC_W-1:0]    pc;
    logic [DEC_PC_W-1:0]    npc;
  } dec_entry_t;

  // Encoded as {s_valid, m_valid} so the valid bits fall straight out of the state.
  localparam logic [1:0] SKID_EMPTY = 2'b00;
  localparam logic [1:0] SKID_ONE   = 2'b01;
  localparam logic [1:0] SKID_FULL  = 2'b11;

  function automatic logic [DEC_PC_W-1:0] sext_imm(input logic [DEC_INSTR_W-1:0] ir);
    return {{(DEC_PC_W - IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  endfunction

endpackage

// File: rtl/decode_stage_reg_if.sv
// Fetch-side and execute-side handshake bundle of the IF/ID stage register.
interface decode_stage_reg_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned PC_W    = 16
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    currpc;
  logic [PC_W-1:0]    newpc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] d_ir;
  logic [PC_W-1:0]    d_pc;
  logic [PC_W-1:0]    d_npc;
  logic [3:0]         d_opcode;
  logic [3:0]         d_rd;
  logic [3:0]         d_rs1;
  logic [3:0]         d_rs2;
  logic [PC_W-1:0]    d_imm;
  logic [PC_W-1:0]    d_br_target;

  modport master (
    output in_valid, ir, currpc, newpc, flush, out_ready,
    input  in_ready, out_valid, d_ir, d_pc, d_npc, d_opcode, d_rd, d_rs1, d_rs2,
           d_imm, d_br_target
  );

  modport slave (
    input  in_valid, ir, currpc, newpc, flush, out_ready,
    output in_ready, out_valid, d_ir, d_pc, d_npc, d_opcode, d_rd, d_rs1, d_rs2,
           d_imm, d_br_target
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer on dec_entry_t; in_ready comes straight from a flop.
module pipe_skid_buf
  import decode_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  dec_entry_t in_data,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output dec_entry_t out_data
);

  logic [1:0] state_q, state_d;
  dec_entry_t m_q, m_d;
  dec_entry_t s_q, s_d;
  logic       accept;
  logic       drain;

  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign out_data  = m_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      // Drops held and incoming entries; data registers keep their stale contents.
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            m_d     = in_data;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && !drain) begin
            s_d     = in_data;
            state_d = SKID_FULL;
          end else if (accept && drain) begin
            m_d = in_data;
          end else if (drain) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (drain) begin
            m_d     = s_q;
            state_d = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SKID_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: rtl/decode_stage_reg.sv
// IF/ID stage register: skid buffer plus instruction field decode.
// Optional saturating stall/bubble counters are built when DECODE_PERF_EN is defined.
module decode_stage_reg
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W = DEC_INSTR_W,
  parameter int unsigned PC_W    = DEC_PC_W
`ifdef DECODE_PERF_EN
  ,
  parameter int unsigned PERF_W  = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  decode_stage_reg_if.slave       bus
`ifdef DECODE_PERF_EN
  ,
  output logic [PERF_W-1:0]       perf_stall,
  output logic [PERF_W-1:0]       perf_bubble
`endif
);

  dec_entry_t         in_entry;
  dec_entry_t         m_entry;
  logic [INSTR_W-1:0] m_ir;
  logic [PC_W-1:0]    m_pc;
  logic [PC_W-1:0]    m_imm;

  assign in_entry = '{ir: bus.ir, pc: bus.currpc, npc: bus.newpc};

  pipe_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_entry),
    .flush     (bus.flush),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (m_entry)
  );

  assign m_ir  = m_entry.ir;
  assign m_pc  = m_entry.pc;
  assign m_imm = sext_imm(m_entry.ir);

  assign bus.d_ir        = m_ir;
  assign bus.d_pc        = m_pc;
  assign bus.d_npc       = m_entry.npc;
  assign bus.d_opcode    = m_ir[OPC_LSB +: FIELD_W];
  assign bus.d_rd        = m_ir[RD_LSB +: FIELD_W];
  assign bus.d_rs1       = m_ir[RS1_LSB +: FIELD_W];
  assign bus.d_rs2       = m_ir[RS2_LSB +: FIELD_W];
  assign bus.d_imm       = m_imm;
  // Halfword-scaled offset; wraps modulo 2^PC_W.
  assign bus.d_br_target = m_pc + {m_imm[PC_W-2:0], 1'b0};

`ifdef DECODE_PERF_EN
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] bubble_q;
  logic              stall_inc;
  logic              bubble_inc;

  assign stall_inc  = bus.out_valid & ~bus.out_ready;
  assign bubble_inc = ~bus.out_valid & ~bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + PERF_W'(1);
      end
      if (bubble_inc && (bubble_q != '1)) begin
        bubble_q <= bubble_q + PERF_W'(1);
      end
    end
  end

  assign perf_stall  = stall_q;
  assign perf_bubble = bubble_q;
`endif

endmodule

// File: tb/tb_decode_stage_reg.sv
// Directed self-checking bench for decode_stage_reg (perf checks run when DECODE_PERF_EN is defined).
module tb_decode_stage_reg;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  decode_stage_reg_if #(.INSTR_W(16), .PC_W(16)) bus ();

`ifdef DECODE_PERF_EN
  logic [15:0] perf_stall;
  logic [15:0] perf_bubble;
`endif

  decode_stage_reg #(
    .INSTR_W (16),
    .PC_W    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave)
`ifdef DECODE_PERF_EN
    ,
    .perf_stall  (perf_stall),
    .perf_bubble (perf_bubble)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] ir, input logic [15:0] pc);
    bus.in_valid = 1'b1;
    bus.ir       = ir;
    bus.currpc   = pc;
    bus.newpc    = pc + 16'd2;
  endtask

  logic [15:0] seen[$];
  logic        acc;
  int          vcount;
`ifdef DECODE_PERF_EN
  logic [15:0] s0;
  logic [15:0] b0;
`endif

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    offer(16'hDEAD, 16'h0100);
    #2;
    rst = 1'b0;

    // Reset held with in_valid asserted
    repeat (3) step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_d_ir", 32'(bus.d_ir), 32'd0);
    check("rst_d_pc", 32'(bus.d_pc), 32'd0);
    check("rst_d_npc", 32'(bus.d_npc), 32'd0);

    // Streaming, first accept right after release
    offer(16'h1234, 16'h0000);
    rst = 1'b1;
    step();
    check("s1_valid", 32'(bus.out_valid), 32'd1);
    check("s1_ir", 32'(bus.d_ir), 32'h1234);
    check("s1_opcode", 32'(bus.d_opcode), 32'd1);
    check("s1_rd", 32'(bus.d_rd), 32'd2);
    check("s1_rs1", 32'(bus.d_rs1), 32'd3);
    check("s1_rs2", 32'(bus.d_rs2), 32'd4);
    check("s1_pc", 32'(bus.d_pc), 32'd0);
    check("s1_npc", 32'(bus.d_npc), 32'd2);
    offer(16'h5678, 16'h0002);
    step();
    check("s2_valid", 32'(bus.out_valid), 32'd1);
    check("s2_ir", 32'(bus.d_ir), 32'h5678);
    check("s2_in_ready", 32'(bus.in_ready), 32'd1);
    offer(16'h9ABC, 16'h0004);
    step();
    check("s3_ir", 32'(bus.d_ir), 32'h9ABC);
    check("s3_pc", 32'(bus.d_pc), 32'h0004);
    bus.in_valid = 1'b0;
    step();
    check("s_empty", 32'(bus.out_valid), 32'd0);

    // Backpressure: two held, third waits
    bus.out_ready = 1'b0;
    offer(16'h1111, 16'h0010);
    step();
    check("bp1_valid", 32'(bus.out_valid), 32'd1);
    check("bp1_in_ready", 32'(bus.in_ready), 32'd1);
    offer(16'h2222, 16'h0012);
    step();
    check("bp2_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp2_hold_ir", 32'(bus.d_ir), 32'h1111);
    offer(16'h3333, 16'h0014);
    step();
    check("bp3_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp3_hold_ir", 32'(bus.d_ir), 32'h1111);
    check("bp3_hold_pc", 32'(bus.d_pc), 32'h0010);
    bus.out_ready = 1'b1;
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen.push_back(bus.d_ir);
      acc = bus.in_valid & bus.in_ready;
      step();
      if (acc) bus.in_valid = 1'b0;
    end
    check("bp_count", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      check("bp_order0", 32'(seen[0]), 32'h1111);
      check("bp_order1", 32'(seen[1]), 32'h2222);
      check("bp_order2", 32'(seen[2]), 32'h3333);
    end

    // Flush from FULL with a pending offer
    bus.out_ready = 1'b0;
    offer(16'hAAAA, 16'h0020);
    step();
    offer(16'hBBBB, 16'h0022);
    step();
    check("fl_full", 32'(bus.in_ready), 32'd0);
    offer(16'hCCCC, 16'h0024);
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_out_valid", 32'(bus.out_valid), 32'd0);
    check("fl_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.out_valid) vcount++;
    end
    check("fl_none_seen", 32'(vcount), 32'd0);
    // Flush discards a same-cycle accept into an empty buffer
    offer(16'hEEEE, 16'h0030);
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_accept_drop", 32'(bus.out_valid), 32'd0);

    // Immediate sign extension and branch-target wrap
    bus.out_ready = 1'b0;
    offer(16'h70FF, 16'h0010);
    step();
    check("imm_neg", 32'(bus.d_imm), 32'hFFFF);
    check("br_neg", 32'(bus.d_br_target), 32'h000E);
    check("imm_opcode", 32'(bus.d_opcode), 32'd7);
    bus.out_ready = 1'b1;
    offer(16'h7001, 16'hFFFE);
    step();
    check("imm_pos", 32'(bus.d_imm), 32'h0001);
    check("br_wrap", 32'(bus.d_br_target), 32'h0000);
    check("npc_wrap", 32'(bus.d_npc), 32'h0000);
    bus.in_valid = 1'b0;
    step();

    // Asynchronous reset while FULL
    bus.out_ready = 1'b0;
    offer(16'h4444, 16'h0040);
    step();
    offer(16'h5555, 16'h0042);
    step();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_d_ir", 32'(bus.d_ir), 32'd0);
    step();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("arst_no_survivor", 32'(bus.out_valid), 32'd0);

`ifdef DECODE_PERF_EN
    bus.out_ready = 1'b0;
    offer(16'h6666, 16'h0050);
    step();
    bus.in_valid = 1'b0;
    s0 = perf_stall;
    b0 = perf_bubble;
    repeat (5) step();
    bus.out_ready = 1'b1;
    step();
    repeat (3) step();
    check("perf_stall_5", 32'(perf_stall - s0), 32'd5);
    check("perf_bubble_3", 32'(perf_bubble - b0), 32'd3);
    s0 = perf_stall;
    repeat (65540) @(posedge clk);
    #1;
    check("perf_bubble_sat", 32'(perf_bubble), 32'hFFFF);
    check("perf_stall_idle", 32'(perf_stall), 32'(s0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
